vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/pixel_prescaler.sv | 41 ++++
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_gen.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator: 640x480@60 defaults,
// derived totals/sync windows, counter width and a width helper.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;

  // 640x480@60 Hz timing, in pixels (horizontal) and lines (vertical)
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Bits needed to count 0..n-1, never less than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_prescaler.sv
// Divides the system clock into a pixel-rate strobe. The strobe is the
// combinational "advance now" condition; the caller registers it.
module pixel_prescaler
  import vga_timing_pkg::cnt_width;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = cnt_width(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("pixel_prescaler: CLK_DIV must be at least 1");
  end

  logic [W-1:0] cnt_q, cnt_d;

  // Strobe on the last phase; the count holds while en is low
  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + W'(1);
    end
  end

  // Phase counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe, h/v counters, sync pulses, blanking and
// line/frame start markers, all registered together so they stay aligned.
module vga_timing_gen
  import vga_timing_pkg::CNT_W;
#(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_tick,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end

  // Sync windows use inclusive upper bounds so a window ending at 1024 still fits
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic             SYNC_ON  = SYNC_POL;
  localparam logic             SYNC_OFF = ~SYNC_POL;

  logic             adv;
  logic             pix_tick_q, pix_tick_d;
  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             blank_q, blank_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  pixel_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (adv)
  );

  // Next counter values, then sync/blank decoded from those next values so
  // every output lands on the same edge as the counter it describes
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    pix_tick_d    = adv;

    if (adv) begin
      if (hcount_q == H_LAST) begin
        hcount_d     = '0;
        line_start_d = 1'b1;
        if (vcount_q == V_LAST) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + CNT_W'(1);
        end
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
    end

    hsync_d = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? SYNC_ON : SYNC_OFF;
    vsync_d = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? SYNC_ON : SYNC_OFF;
    blank_d = (hcount_d >= H_ACT) || (vcount_d >= V_ACT);
  end

  // Raster state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_tick_q    <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_tick_q    <= pix_tick_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Instance A: default 640x480 timing, CLK_DIV=2,
// active-low syncs. Instance B: small 32x20 raster, CLK_DIV=1, active-high
// syncs, so whole frames fit in a short run. Expected outputs come from a
// linear pixel-index model and are queued per clock, then popped and compared.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       tick;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       ls;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, en_a = 1'b0;
  logic       rst_b = 1'b1, en_b = 1'b0;
  logic       tick_a, hs_a, vs_a, blank_a, ls_a, fs_a;
  logic       tick_b, hs_b, vs_b, blank_b, ls_b, fs_b;
  logic [9:0] h_a, v_a, h_b, v_b;
  obs_t       obs_a, obs_b;

  assign obs_a = {tick_a, h_a, v_a, hs_a, vs_a, blank_a, ls_a, fs_a};
  assign obs_b = {tick_b, h_b, v_b, hs_b, vs_b, blank_b, ls_b, fs_b};

  vga_timing_gen #(
    .CLK_DIV  (2),
    .SYNC_POL (1'b0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .pix_tick(tick_a), .hcount(h_a), .vcount(v_a),
    .hsync(hs_a), .vsync(vs_a), .blank(blank_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (4),
    .CLK_DIV  (1),
    .SYNC_POL (1'b1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .pix_tick(tick_b), .hcount(h_b), .vcount(v_b),
    .hsync(hs_b), .vsync(vs_b), .blank(blank_b), .line_start(ls_b), .frame_start(fs_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  obs_t        q_a[$], q_b[$];
  obs_t        e;
  int unsigned a_phase = 0, a_pix = 0;
  int unsigned b_phase = 0, b_pix = 0;

  function automatic obs_t exp_obs(input int unsigned pix, input logic tick,
                                   input int unsigned ht, input int unsigned vt,
                                   input int unsigned ha, input int unsigned va,
                                   input int unsigned hss, input int unsigned hse,
                                   input int unsigned vss, input int unsigned vse,
                                   input logic pol);
    obs_t r;
    int unsigned h, v;
    h = pix % ht;
    v = (pix / ht) % vt;
    r.tick  = tick;
    r.h     = 10'(h);
    r.v     = 10'(v);
    r.hs    = (h >= hss && h < hse) ? pol : ~pol;
    r.vs    = (v >= vss && v < vse) ? pol : ~pol;
    r.blank = (h >= ha) || (v >= va);
    r.ls    = tick && (h == 0);
    r.fs    = tick && (h == 0) && (v == 0);
    return r;
  endfunction

  function automatic obs_t exp_a(input int unsigned pix, input logic tick);
    return exp_obs(pix, tick, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0);
  endfunction

  function automatic obs_t exp_b(input int unsigned pix, input logic tick);
    return exp_obs(pix, tick, 32, 20, 16, 12, 20, 26, 14, 16, 1'b1);
  endfunction

  // Drive one clock of instance A and queue what it must show afterwards
  task automatic step_a(input logic en_v);
    logic t;
    en_a = en_v;
    t = en_v && (a_phase == 1);
    if (en_v) a_phase = t ? 0 : a_phase + 1;
    if (t) a_pix++;
    q_a.push_back(exp_a(a_pix, t));
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic en_v);
    logic t;
    en_b = en_v;
    t = en_v;
    if (t) b_pix++;
    q_b.push_back(exp_b(b_pix, t));
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs_a !== exp_a(0, 1'b0)) begin
      n_fail++; $display("FAIL reset_a got=%h want=%h", obs_a, exp_a(0, 1'b0));
    end
    n_checks++;
    if (hs_a !== 1'b1 || vs_a !== 1'b1) begin
      n_fail++; $display("FAIL reset_a_sync got=%b%b want=11", hs_a, vs_a);
    end
    n_checks++;
    if (obs_b !== exp_b(0, 1'b0)) begin
      n_fail++; $display("FAIL reset_b got=%h want=%h", obs_b, exp_b(0, 1'b0));
    end
    rst_a = 1'b0; rst_b = 1'b0;
    a_phase = 0; a_pix = 0; b_phase = 0; b_pix = 0;
  endtask

  task automatic test_tick_spacing;
    int unsigned first_tick;
    first_tick = 0;
    for (int unsigned k = 1; k <= 8; k++) begin
      step_a(1'b1);
      e = q_a.pop_front(); n_checks++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL tick_spacing cyc=%0d got=%h want=%h", k, obs_a, e);
      end
      if (tick_a === 1'b1 && first_tick == 0) begin
        first_tick = k;
        n_checks++;
        if (h_a !== 10'd1) begin
          n_fail++; $display("FAIL first_tick_hcount got=%0d want=1", h_a);
        end
      end
    end
    n_checks++;
    if (first_tick != 2) begin
      n_fail++; $display("FAIL first_tick_cycle got=%0d want=2", first_tick);
    end
  endtask

  task automatic test_line;
    int unsigned hs_pix, ls_cnt, guard;
    logic prev_blank;
    hs_pix = 0; ls_cnt = 0; guard = 0; prev_blank = blank_a;
    while (a_pix < 805 && guard < 2000) begin
      step_a(1'b1);
      guard++;
      e = q_a.pop_front(); n_checks++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL line got=%h want=%h", obs_a, e);
      end
      if (tick_a === 1'b1 && hs_a === 1'b0) hs_pix++;
      if (ls_a === 1'b1) ls_cnt++;
      if (blank_a === 1'b1 && prev_blank === 1'b0) begin
        n_checks++;
        if (h_a !== 10'd640) begin
          n_fail++; $display("FAIL blank_rise_h got=%0d want=640", h_a);
        end
      end
      prev_blank = blank_a;
    end
    n_checks++;
    if (a_pix < 805) begin
      n_fail++; $display("FAIL line_timeout got=%0d want=805", a_pix);
    end
    n_checks++;
    if (hs_pix != 96) begin
      n_fail++; $display("FAIL hsync_width got=%0d want=96", hs_pix);
    end
    n_checks++;
    if (ls_cnt != 1) begin
      n_fail++; $display("FAIL line_start_count got=%0d want=1", ls_cnt);
    end
    n_checks++;
    if (v_a !== 10'd1) begin
      n_fail++; $display("FAIL vcount_after_line got=%0d want=1", v_a);
    end
  endtask

  task automatic test_enable_freeze;
    int unsigned guard, first301;
    guard = 0; first301 = 0;
    while (a_pix < 1100 && guard < 1000) begin
      step_a(1'b1);
      guard++;
      e = q_a.pop_front(); n_checks++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL pre_freeze got=%h want=%h", obs_a, e);
      end
    end
    for (int unsigned k = 0; k < 5; k++) begin
      step_a(1'b0);
      e = q_a.pop_front(); n_checks++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL freeze got=%h want=%h", obs_a, e);
      end
      n_checks++;
      if (h_a !== 10'd300 || tick_a !== 1'b0) begin
        n_fail++; $display("FAIL freeze_hold got=h%0d/t%b want=h300/t0", h_a, tick_a);
      end
    end
    for (int unsigned k = 1; k <= 6; k++) begin
      step_a(1'b1);
      e = q_a.pop_front(); n_checks++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL resume got=%h want=%h", obs_a, e);
      end
      if (h_a === 10'd301 && first301 == 0) first301 = k;
    end
    n_checks++;
    if (first301 != 2) begin
      n_fail++; $display("FAIL resume_cycle got=%0d want=2", first301);
    end
  endtask

  task automatic test_reset_mid_frame_a;
    int unsigned guard;
    guard = 0;
    while (a_pix < 1500 && guard < 1000) begin
      step_a(1'b1);
      guard++;
      e = q_a.pop_front(); n_checks++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL pre_reset_a got=%h want=%h", obs_a, e);
      end
    end
    #2 rst_a = 1'b1;
    #1;
    n_checks++;
    if (obs_a !== exp_a(0, 1'b0)) begin
      n_fail++; $display("FAIL async_reset_a got=%h want=%h", obs_a, exp_a(0, 1'b0));
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs_a !== exp_a(0, 1'b0)) begin
      n_fail++; $display("FAIL reset_hold_a got=%h want=%h", obs_a, exp_a(0, 1'b0));
    end
    rst_a = 1'b0;
    a_phase = 0; a_pix = 0; q_a.delete();
    for (int unsigned k = 0; k < 6; k++) begin
      step_a(1'b1);
      e = q_a.pop_front(); n_checks++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL restart_a got=%h want=%h", obs_a, e);
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_frame_b;
    int unsigned cyc, fs_cnt, fs_first, fs_second, vs_pix, blank_pix;
    cyc = 0; fs_cnt = 0; fs_first = 0; fs_second = 0; vs_pix = 0; blank_pix = 0;
    for (int unsigned k = 0; k < 1288; k++) begin
      step_b(1'b1);
      cyc++;
      e = q_b.pop_front(); n_checks++;
      if (obs_b !== e) begin
        n_fail++; $display("FAIL frame_b got=%h want=%h", obs_b, e);
      end
      if (fs_cnt == 1 && tick_b === 1'b1) begin
        if (vs_b === 1'b1) vs_pix++;
        if (blank_b === 1'b1) blank_pix++;
      end
      if (fs_b === 1'b1) begin
        n_checks++;
        if (ls_b !== 1'b1 || blank_b !== 1'b0) begin
          n_fail++; $display("FAIL fs_align got=ls%b/bl%b want=ls1/bl0", ls_b, blank_b);
        end
        if (fs_cnt == 0) fs_first = cyc;
        else if (fs_cnt == 1) fs_second = cyc;
        fs_cnt++;
      end
    end
    n_checks++;
    if (fs_cnt != 2) begin
      n_fail++; $display("FAIL fs_count got=%0d want=2", fs_cnt);
    end
    n_checks++;
    if (fs_second - fs_first != 640) begin
      n_fail++; $display("FAIL frame_period got=%0d want=640", fs_second - fs_first);
    end
    n_checks++;
    if (vs_pix != 64) begin
      n_fail++; $display("FAIL vsync_width got=%0d want=64", vs_pix);
    end
    n_checks++;
    if (blank_pix != 448) begin
      n_fail++; $display("FAIL blank_pixels got=%0d want=448", blank_pix);
    end
  endtask

  task automatic test_reset_mid_frame_b;
    int unsigned guard;
    guard = 0;
    while (b_pix < 1628 && guard < 1000) begin
      step_b(1'b1);
      guard++;
      e = q_b.pop_front(); n_checks++;
      if (obs_b !== e) begin
        n_fail++; $display("FAIL pre_reset_b got=%h want=%h", obs_b, e);
      end
    end
    #2 rst_b = 1'b1;
    #1;
    n_checks++;
    if (obs_b !== exp_b(0, 1'b0)) begin
      n_fail++; $display("FAIL async_reset_b got=%h want=%h", obs_b, exp_b(0, 1'b0));
    end
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    b_phase = 0; b_pix = 0; q_b.delete();
    for (int unsigned k = 0; k < 4; k++) begin
      step_b(1'b1);
      e = q_b.pop_front(); n_checks++;
      if (obs_b !== e) begin
        n_fail++; $display("FAIL restart_b got=%h want=%h", obs_b, e);
      end
    end
    en_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick_spacing();
    test_line();
    test_enable_freeze();
    test_reset_mid_frame_a();
    test_frame_b();
    test_reset_mid_frame_b();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
